// File: rtl/alu_seq_driver_if.sv
// Host request/response and ALU drive/sense signals of the ALU sequencer.
// Optional req_chain line is present only when ALU_SEQ_CHAIN_EN is defined.
interface alu_seq_driver_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_cmd;
  logic [7:0]  req_a;
  logic [7:0]  req_b;
`ifdef ALU_SEQ_CHAIN_EN
  logic        req_chain;
`endif
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        busy;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_cmd;
  logic        alu_oe;
  logic [15:0] alu_d;

  // Host plus ALU side: issues requests, accepts responses, drives the result bus.
  modport master (
    output req_valid, req_cmd, req_a, req_b, rsp_ready, alu_d,
`ifdef ALU_SEQ_CHAIN_EN
    output req_chain,
`endif
    input  req_ready, rsp_valid, rsp_data, busy, alu_a, alu_b, alu_cmd, alu_oe
  );

  modport slave (
    input  req_valid, req_cmd, req_a, req_b, rsp_ready, alu_d,
`ifdef ALU_SEQ_CHAIN_EN
    input  req_chain,
`endif
    output req_ready, rsp_valid, rsp_data, busy, alu_a, alu_b, alu_cmd, alu_oe
  );
endinterface

// File: rtl/alu_seq_driver.sv
// ALU sequencer: latch request, settle SETTLE_CYCLES with oe low, pulse oe one cycle, capture result.
// Response after SETTLE_CYCLES+2 cycles; holds in RESP until rsp_ready. Macro ALU_SEQ_CHAIN_EN adds req_chain.
module alu_seq_driver #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input logic             clk,
  input logic             rst_n,
  alu_seq_driver_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ENABLE,
    RESP
  } state_t;

  localparam logic [3:0] SETTLE = SETTLE_CYCLES[3:0];

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [7:0]  alu_a_q;
  logic [7:0]  alu_b_q;
  logic [3:0]  alu_cmd_q;
  logic        alu_oe_q;
  logic        req_ready_q;
  logic        busy_q;
  logic        rsp_valid_q;
  logic [15:0] rsp_data_q;
  logic [7:0]  alu_a_d;

  // Chaining feeds the low byte of the previous result back in as operand A.
`ifdef ALU_SEQ_CHAIN_EN
  assign alu_a_d = bus.req_chain ? rsp_data_q[7:0] : bus.req_a;
`else
  assign alu_a_d = bus.req_a;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      alu_a_q     <= 8'd0;
      alu_b_q     <= 8'd0;
      alu_cmd_q   <= 4'd0;
      alu_oe_q    <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            alu_a_q     <= alu_a_d;
            alu_b_q     <= bus.req_b;
            alu_cmd_q   <= bus.req_cmd;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (SETTLE != 4'd0) begin
              state_q <= SETUP;
              cnt_q   <= SETTLE;
            end else begin
              state_q  <= ENABLE;
              alu_oe_q <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (cnt_q <= 4'd1) begin
            state_q  <= ENABLE;
            alu_oe_q <= 1'b1;
            cnt_q    <= 4'd0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ENABLE: begin
          rsp_data_q  <= bus.alu_d;
          alu_oe_q    <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          // Return to IDLE only; the next accept happens one edge later.
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_cmd   = alu_cmd_q;
  assign bus.alu_oe    = alu_oe_q;

endmodule
